video_line_fetcher: RTL

Prefetches one PCW display line ahead of the video controller. On each line it reads the 16-bit roller-RAM entry for the next line, then the 90 pixel bytes of that line from shared memory over a req/ack handshake, into a ping-pong line buffer. The video controller reads the front buffer by column with fixed one-cycle latency and never drives memory addresses directly. Sits between the memory arbiter (upstream) and `video_controller` pixel shifting (downstream).

---
 rtl/video_line_fetcher_if.sv | 22 ++
 rtl/video_line_fetcher.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/video_line_fetcher_if.sv
// Shared-memory read port used by the line fetcher.
// One outstanding request; ack marks data valid.
interface video_line_fetcher_if;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_din;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_din
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_din
  );
endinterface

// File: rtl/video_line_fetcher.sv
// PCW video line prefetcher: roller-RAM lookup plus
// 90-byte line fetch into a ping-pong line buffer.
module video_line_fetcher #(
  parameter int COLS  = 90,
  parameter int LINES = 256
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic [7:0] roller_ptr,
  input  logic [7:0] yscroll,
  video_line_fetcher_if.master mem,
  input  logic [6:0] rd_col,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       overrun
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [7:0] LAST_LN  = 8'(LINES - 1);

  typedef enum logic [2:0] {
    IDLE, RR_LSB, RR_MSB, PIX, DRAIN
  } state_t;

  state_t      state, state_d;
  logic [16:0] addr, addr_d;
  logic [6:0]  k, k_d;
  logic [7:0]  wlo, wlo_d;
  logic [7:0]  rp, rp_d;
  logic [7:0]  ys, ys_d;
  logic [7:0]  ln, ln_d;
  logic [7:0]  idx, idx_d;
  logic        sel, sel_d;
  logic        ovr_d;
  logic        drain_go, drain_go_d;
  logic        go;
  logic        acked;
  logic        wr_en;

  logic [7:0] buf0 [COLS];
  logic [7:0] buf1 [COLS];

  assign mem.mem_req  = (state != IDLE);
  assign mem.mem_addr = addr;
  assign busy         = (state != IDLE);
  assign acked        = mem.mem_req & mem.mem_ack;
  assign idx          = ln + ys;

  always_comb begin
    state_d    = state;
    addr_d     = addr;
    k_d        = k;
    wlo_d      = wlo;
    rp_d       = rp;
    ys_d       = ys;
    ln_d       = ln;
    sel_d      = sel;
    ovr_d      = overrun;
    drain_go_d = drain_go;
    go         = 1'b0;
    wr_en      = 1'b0;
    if (frame_start) begin
      rp_d = roller_ptr;
      ys_d = yscroll;
      ln_d = '0;
      go   = 1'b1;
    end else if (line_start) begin
      sel_d = ~sel;
      if (ln < LAST_LN) begin
        ln_d = ln + 8'd1;
        go   = 1'b1;
      end
    end
    idx_d = ln_d + ys_d;
    if (frame_start | line_start) begin
      if (state != IDLE) ovr_d = 1'b1;
      // An in-flight request must complete before a new address.
      if (state != IDLE && !acked) begin
        state_d    = DRAIN;
        drain_go_d = go;
      end else if (go) begin
        state_d = RR_LSB;
        addr_d  = {rp_d, idx_d, 1'b0};
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: state_d = IDLE;
        RR_LSB: if (acked) begin
          wlo_d   = mem.mem_din;
          addr_d  = addr + 17'd1;
          state_d = RR_MSB;
        end
        RR_MSB: if (acked) begin
          addr_d  = {mem.mem_din, wlo[7:3],
                     1'b0, wlo[2:0]};
          k_d     = '0;
          state_d = PIX;
        end
        PIX: if (acked) begin
          wr_en = 1'b1;
          if (k == LAST_COL) begin
            state_d = IDLE;
          end else begin
            k_d    = k + 7'd1;
            addr_d = addr + 17'd8;
          end
        end
        DRAIN: if (acked) begin
          if (drain_go) begin
            state_d = RR_LSB;
            addr_d  = {rp, idx, 1'b0};
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      k        <= '0;
      wlo      <= '0;
      rp       <= '0;
      ys       <= '0;
      ln       <= '0;
      sel      <= 1'b0;
      overrun  <= 1'b0;
      drain_go <= 1'b0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      k        <= k_d;
      wlo      <= wlo_d;
      rp       <= rp_d;
      ys       <= ys_d;
      ln       <= ln_d;
      sel      <= sel_d;
      overrun  <= ovr_d;
      drain_go <= drain_go_d;
    end
  end

  // sel=0: buf0 is front, buf1 is back.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      if (sel) buf0[k] <= mem.mem_din;
      else     buf1[k] <= mem.mem_din;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_col <= LAST_COL) begin
      rd_data <= sel ? buf1[rd_col] : buf0[rd_col];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
